fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the five-stage RISC-V pipeline. It keeps its own shadow pipeline of destination-register metadata for EX, MEM and WB. From that it produces the registered 2-bit select for the two EX-stage operand 4:1 muxes, plus the load-use stall/bubble control. It sits beside the ID/EX pipeline register and is advanced by the same clock and enables.

## Interface
Parameters
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width

Ports
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous reset, active-low
- hold_i  in  1  global freeze (e.g. memory wait); all state holds
- flush_i  in  1  taken branch resolved in ID; discard the ID instruction
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i, id_rs2_i  in  REG_AW  source registers of the ID instruction
- id_use_rs1_i, id_use_rs2_i  in  1  ID instruction actually reads rs1/rs2
- id_rd_i  in  REG_AW  destination of the ID instruction
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- fwd_a_o, fwd_b_o  out  2  registered selects for the EX operand A/B muxes
- stall_o  out  1  load-use stall: hold PC and IF/ID, insert bubble into ID/EX
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Shadow slots EX, MEM, WB each hold {valid, rd, regwrite, memread}. A slot "writes r" when valid & regwrite & rd==r & r!=0.
- Select encoding:
  - 00 = register-file operand
  - 01 = WB write-back data
  - 10 = MEM ALU result
  - 11 = reserved, never driven
- Next-cycle select per operand, evaluated in ID for the instruction entering EX. Evaluation is independent for A (rs1) and B (rs2). If the operand is not used (id_use=0), the select is 00.
  - Current EX slot writes rs (it becomes MEM next cycle) and is not a load: 10.
  - Else current MEM slot writes rs (it becomes WB next cycle): 01.
  - Else 00.
  - A match in the current WB slot needs no forwarding, because the register file is write-first. Result: 00.
- stall_o = id_valid_i & EX slot valid & memread & rd!=0 & ((id_use_rs1_i & rd==rs1) | (id_use_rs2_i & rd==rs2)) & !flush_i. Combinational.
- Slot advance, when hold_i=0:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes the ID metadata, or a bubble (valid=0) if stall_o, flush_i or !id_valid_i.
  - fwd_a_o/fwd_b_o load the computed selects, or 00 on a bubble.
- Priority: hold_i > flush_i > load-use stall.
- On hold_i=1, slots, selects and counter all hold. stall_o remains combinational.
- stall_cnt_o increments on each cycle with stall_o & !hold_i, and saturates at all-ones.

## Timing
- Reset (rst_i low, asynchronous):
  - All slots invalid.
  - fwd_a_o = fwd_b_o = 00.
  - stall_cnt_o = 0.
  - With slots invalid, stall_o evaluates to 0.
- Select latency: 1 cycle. The select computed in ID is valid for the whole following EX cycle.
- Load-use: exactly one stall cycle per load-use pair. On the next cycle the load sits in MEM and the dependent instruction's select is recomputed. The dependency is resolved via 01 as the load reaches WB.
- Stall and flush in the same cycle: flush wins, stall_o=0, bubble inserted.
- Reset deasserted mid-stream: the first post-reset instruction sees empty slots and selects 00.

## Structure
- Define.v holds the following, shared with the datapath mux instances:
  - `REG_ADDR_LEN
  - `FWD_RF (2'b00)
  - `FWD_WB (2'b01)
  - `FWD_MEM (2'b10)
- Sub-module fwd_match: a combinational per-operand priority compare of rs against the EX/MEM slots, producing a 2-bit select and a load-hit flag. It is instantiated twice, once for A and once for B.

## Test plan
- Back-to-back "add x5,…" then "sub x6,x5,x5": second instruction in EX has fwd_a_o=fwd_b_o=10, stall_o never 1.
- add x5 → nop → "or x7,x5,x0": fwd_a_o=01, fwd_b_o=00.
- "lw x8,0(x1)" then "add x9,x8,x2": stall_o=1 for exactly one cycle, EX slot bubble (fwd=00). The add then has fwd_a_o=01. stall_cnt_o increments by 1.
- Writes to x0 (rd=0, regwrite=1) followed by a reader of x0: all selects 00, no stall.
- Load-use hazard with flush_i=1 in the same cycle: stall_o=0, bubble, counter unchanged. Same scenario with hold_i=1 for 3 cycles: outputs and counter frozen.
- Assert rst_i low mid-sequence with a pending forward: fwd_*_o go 00 immediately (asynchronous) and stall_cnt_o=0. After release, the next dependent instruction gets 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding and load-use hazard controller.
// The select encoding matches the datapath operand muxes.
package fwd_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int REG_AW_DEFAULT = 5;
  localparam int CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// Per-operand priority compare of one ID source register against the shadow
// EX/MEM/WB destinations; yields the next forwarding select and a load-hit flag.
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic rs_nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign rs_nonzero = (rs != '0);
  assign ex_hit     = ex_valid  & ex_regwrite  & (ex_rd  == rs) & rs_nonzero;
  assign mem_hit    = mem_valid & mem_regwrite & (mem_rd == rs) & rs_nonzero;
  assign wb_hit     = wb_valid  & wb_regwrite  & (wb_rd  == rs) & rs_nonzero;

  // A load in EX has no data yet; load_hit raises the stall instead.
  assign load_hit = use_rs & ex_valid & ex_memread & (ex_rd != '0) & (ex_rd == rs);

  // NOTE: the default assignment first keeps this always_comb free of latches.
  always_comb begin
    sel = FWD_RF;
    if (!use_rs) begin
      sel = FWD_RF;
    end else if (ex_hit && !ex_memread) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end else if (wb_hit) begin
      // The register file is write-first, so a WB producer is read directly.
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the five-stage pipeline; keeps a
// shadow of destination metadata for EX/MEM/WB and registers the EX operand selects.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } dst_t;

  // Load-ness only matters while the producer sits in EX, so it is kept for EX alone.
  dst_t ex_q;
  dst_t mem_q;
  dst_t wb_q;
  logic ex_load_q;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       hit_a;
  logic       hit_b;
  logic       bubble;

  fwd_match #(.REG_AW(REG_AW)) u_match_a (
    .rs           (id_rs1_i),
    .use_rs       (id_use_rs1_i),
    .ex_valid     (ex_q.valid),
    .ex_rd        (ex_q.rd),
    .ex_regwrite  (ex_q.regwrite),
    .ex_memread   (ex_load_q),
    .mem_valid    (mem_q.valid),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .wb_valid     (wb_q.valid),
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (sel_a),
    .load_hit     (hit_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_b (
    .rs           (id_rs2_i),
    .use_rs       (id_use_rs2_i),
    .ex_valid     (ex_q.valid),
    .ex_rd        (ex_q.rd),
    .ex_regwrite  (ex_q.regwrite),
    .ex_memread   (ex_load_q),
    .mem_valid    (mem_q.valid),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .wb_valid     (wb_q.valid),
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (sel_b),
    .load_hit     (hit_b)
  );

  // Flush outranks the load-use stall; the ID instruction is discarded anyway.
  assign stall_o = id_valid_i & (hit_a | hit_b) & ~flush_i;
  assign bubble  = stall_o | flush_i | ~id_valid_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, and the asynchronous reset sits in the sensitivity list.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_load_q   <= 1'b0;
      fwd_a_o     <= FWD_RF;
      fwd_b_o     <= FWD_RF;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q      <= '0;
        ex_load_q <= 1'b0;
        fwd_a_o   <= FWD_RF;
        fwd_b_o   <= FWD_RF;
      end else begin
        ex_q      <= dst_t'{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i};
        ex_load_q <= id_memread_i;
        fwd_a_o   <= sel_a;
        fwd_b_o   <= sel_b;
      end
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: an issue-history model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          use1 = 1'b0;
  logic          use2 = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          regwrite = 1'b0;
  logic          memread = 1'b0;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;
  logic [CW-1:0] cnt;

  int n_total = 0;
  int n_bad = 0;

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .hold_i        (hold),
    .flush_i       (flush),
    .id_valid_i    (id_valid),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .id_use_rs1_i  (use1),
    .id_use_rs2_i  (use2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (regwrite),
    .id_memread_i  (memread),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_o       (stall),
    .stall_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the three most recent instructions issued into EX (0 = now in EX).
  typedef struct {
    logic          valid;
    logic [AW-1:0] rd;
    logic          rw;
    logic          ld;
  } ent_t;

  ent_t          hist[3];
  logic [1:0]    exp_a = 2'b00;
  logic [1:0]    exp_b = 2'b00;
  logic [CW-1:0] exp_cnt = '0;

  function automatic logic writes(input ent_t e, input logic [AW-1:0] r);
    return e.valid && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic logic [1:0] model_sel(input logic [AW-1:0] rs, input logic u);
    if (!u) return 2'b00;
    if (writes(hist[0], rs) && !hist[0].ld) return 2'b10;
    if (writes(hist[1], rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    return id_valid && hist[0].valid && hist[0].ld && (hist[0].rd != 0) &&
           ((use1 && hist[0].rd == rs1) || (use2 && hist[0].rd == rs2)) && !flush;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{valid: 1'b0, rd: '0, rw: 1'b0, ld: 1'b0};
    exp_a   = 2'b00;
    exp_b   = 2'b00;
    exp_cnt = '0;
  endtask

  initial model_clear();

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else if (!hold) begin
      logic st;
      logic bub;
      st  = model_stall();
      bub = st || flush || !id_valid;
      exp_a = bub ? 2'b00 : model_sel(rs1, use1);
      exp_b = bub ? 2'b00 : model_sel(rs2, use2);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (bub) hist[0] = '{valid: 1'b0, rd: '0, rw: 1'b0, ld: 1'b0};
      else     hist[0] = '{valid: 1'b1, rd: id_rd, rw: regwrite, ld: memread};
      if (st && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_fwd_a", 32'(fwd_a), 32'(exp_a));
    check("model_fwd_b", 32'(fwd_b), 32'(exp_b));
    check("model_stall", 32'(stall), 32'(model_stall()));
    check("model_cnt", 32'(cnt), 32'(exp_cnt));
  end

  task automatic step(input logic v, input logic [AW-1:0] d, input logic rw, input logic mr,
                      input logic [AW-1:0] r1, input logic u1, input logic [AW-1:0] r2,
                      input logic u2, input logic h, input logic f);
    @(posedge clk);
    #1;
    id_valid = v;
    id_rd    = d;
    regwrite = rw;
    memread  = mr;
    rs1      = r1;
    use1     = u1;
    rs2      = r2;
    use2     = u2;
    hold     = h;
    flush    = f;
  endtask

  task automatic alu(input logic [AW-1:0] d, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                     input logic h = 1'b0, input logic f = 1'b0);
    step(1'b1, d, 1'b1, 1'b0, r1, 1'b1, r2, 1'b1, h, f);
  endtask

  task automatic ld(input logic [AW-1:0] d, input logic [AW-1:0] r1);
    step(1'b1, d, 1'b1, 1'b1, r1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_fwd_a", 32'(fwd_a), 0);
    check("reset_fwd_b", 32'(fwd_b), 0);
    check("reset_stall", 32'(stall), 0);
    check("reset_cnt", 32'(cnt), 0);
    rst_n = 1'b1;

    // add x5 ; sub x6,x5,x5 -> MEM forward on both operands
    alu(5, 1, 2);
    alu(6, 5, 5);
    nop();
    check("b2b_fwd_a", 32'(fwd_a), 2);
    check("b2b_fwd_b", 32'(fwd_b), 2);

    // add x5 ; nop ; or x7,x5,x0 -> WB forward on A only
    alu(5, 1, 2);
    nop();
    alu(7, 5, 0);
    nop();
    check("gap_fwd_a", 32'(fwd_a), 1);
    check("gap_fwd_b", 32'(fwd_b), 0);

    // lw x8 ; add x9,x8,x2 -> one stall, bubble, then WB forward
    ld(8, 1);
    alu(9, 8, 2);
    #1 check("lu_stall_on", 32'(stall), 1);
    alu(9, 8, 2);
    #1 check("lu_stall_off", 32'(stall), 0);
    check("lu_bubble_fwd_a", 32'(fwd_a), 0);
    nop();
    check("lu_fwd_a", 32'(fwd_a), 1);
    check("lu_fwd_b", 32'(fwd_b), 0);
    check("lu_cnt", 32'(cnt), 1);

    // writes to x0 never forward and never stall
    alu(0, 1, 2);
    alu(3, 0, 0);
    nop();
    check("x0_fwd_a", 32'(fwd_a), 0);
    check("x0_fwd_b", 32'(fwd_b), 0);
    ld(0, 1);
    alu(4, 0, 0);
    #1 check("x0_load_stall", 32'(stall), 0);
    nop();
    nop();

    // load-use with flush in the same cycle -> no stall, bubble, counter unchanged
    ld(8, 1);
    alu(9, 8, 2, 1'b0, 1'b1);
    #1 check("flush_stall", 32'(stall), 0);
    nop();
    check("flush_fwd_a", 32'(fwd_a), 0);
    check("flush_cnt", 32'(cnt), 1);

    // load-use under a 3-cycle hold -> everything frozen, stall still visible
    alu(12, 1, 2);
    alu(13, 12, 2);
    ld(10, 13);
    alu(11, 10, 10, 1'b1);
    #1 check("hold_stall", 32'(stall), 1);
    for (int i = 0; i < 3; i++) begin
      alu(11, 10, 10, 1'b1);
      #1;
      check("hold_fwd_a", 32'(fwd_a), 2);
      check("hold_fwd_b", 32'(fwd_b), 0);
      check("hold_cnt", 32'(cnt), 1);
    end
    alu(11, 10, 10);
    alu(11, 10, 10);
    nop();
    check("unhold_fwd_a", 32'(fwd_a), 1);
    check("unhold_fwd_b", 32'(fwd_b), 1);
    check("unhold_cnt", 32'(cnt), 2);

    // asynchronous reset with a forward pending
    alu(14, 1, 2);
    alu(15, 14, 14);
    nop();
    check("prerst_fwd_a", 32'(fwd_a), 2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_fwd_b", 32'(fwd_b), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_stall", 32'(stall), 0);
    nop();
    rst_n = 1'b1;
    alu(16, 15, 14);
    nop();
    check("postrst_fwd_a", 32'(fwd_a), 0);
    check("postrst_fwd_b", 32'(fwd_b), 0);

    // saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      ld(20, 1);
      alu(21, 20, 20);
      alu(21, 20, 20);
    end
    nop();
    nop();
    check("sat_cnt", 32'(cnt), 32'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
